// File: rtl/nr4sdm_pkg.sv
// Shared widths and correction constant for the NR4SD- multiplier recoder.
package nr4sdm_pkg;

    localparam int A_W   = 16;
    localparam int NDIG  = A_W / 2 - 1;
    localparam int COR_W = 2 * A_W;

    // A negative digit's partial product is the 17-bit one's complement of |d|*B.
    // That is off by (2^(A_W+1) - 1) from -|d|*B, so each one contributes this
    // amount, scaled to its digit position, to the correction word.
    localparam logic [COR_W-1:0] K_NEG = COR_W'(1) - (COR_W'(1) << (A_W + 1));

    // Correction contribution of digit position j when that digit is negative.
    function automatic logic [COR_W-1:0] cor_term(input logic neg, input int j);
        return neg ? (K_NEG << (2 * j)) : '0;
    endfunction

endpackage

// File: rtl/nr4sdm_digit_slice.sv
// One NR4SD- digit: an HA on the even bit, an HA* (OR carry) on the odd bit,
// then decode into PP generator selects.
module nr4sdm_digit_slice (
    input  logic a_lo,
    input  logic a_hi,
    input  logic c_in,
    output logic np,
    output logic nm,
    output logic c_out,
    output logic one_p,
    output logic one_m,
    output logic two_m
);

    logic c_mid;

    // Carry chain and select decode; digit value is -2*nm + np.
    always_comb begin
        np    = a_lo ^ c_in;
        c_mid = a_lo & c_in;
        nm    = a_hi ^ c_mid;
        c_out = a_hi | c_mid;
        one_p = ~nm & np;
        one_m = nm & np;
        two_m = nm & ~np;
    end

endmodule

// File: rtl/nr4sdm_recoder_unit.sv
// Registered NR4SD- recoder: NDIG NR4SD- digits plus a Modified-Booth MSB digit,
// with the correction word the PP summation needs for negative digits.
module nr4sdm_recoder_unit
    import nr4sdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [A_W-1:0]   a,
    output logic [NDIG-1:0]  nm,
    output logic [NDIG-1:0]  np,
    output logic [NDIG-1:0]  one_p,
    output logic [NDIG-1:0]  one_m,
    output logic [NDIG-1:0]  two_m,
    output logic             sign,
    output logic             one,
    output logic             two,
    output logic [COR_W-1:0] cor,
    output logic             out_vld
);

    logic [NDIG:0]      c;
    logic [NDIG-1:0]    nm_d, np_d, one_p_d, one_m_d, two_m_d;
    logic               sign_d, one_d, two_d;
    logic [COR_W-1:0]   cor_d;

    assign c[0] = 1'b0;

    for (genvar j = 0; j < NDIG; j++) begin : g_slice
        nr4sdm_digit_slice u_slice (
            .a_lo  (a[2*j]),
            .a_hi  (a[2*j+1]),
            .c_in  (c[j]),
            .np    (np_d[j]),
            .nm    (nm_d[j]),
            .c_out (c[j+1]),
            .one_p (one_p_d[j]),
            .one_m (one_m_d[j]),
            .two_m (two_m_d[j])
        );
    end

    // MSB digit absorbs the final carry: -2*a[15] + a[14] + c14, range -2..+2.
    // sign=1 with zero magnitude is allowed; the PP side treats it as ~0.
    always_comb begin
        sign_d = a[A_W-1];
        one_d  = a[A_W-2] ^ c[NDIG];
        two_d  = (a[A_W-1] ^ a[A_W-2]) & ~one_d;
    end

    // Correction word: one K_NEG term per negative digit, weighted by 4^j.
    always_comb begin
        cor_d = cor_term(sign_d, NDIG);
        for (int j = 0; j < NDIG; j++) begin
            cor_d = cor_d + cor_term(one_m_d[j] | two_m_d[j], j);
        end
    end

    // Output register; an all-zero reset state is a valid all-zero-digit recoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            nm      <= '0;
            np      <= '0;
            one_p   <= '0;
            one_m   <= '0;
            two_m   <= '0;
            sign    <= 1'b0;
            one     <= 1'b0;
            two     <= 1'b0;
            cor     <= '0;
            out_vld <= 1'b0;
        end else if (en) begin
            nm      <= nm_d;
            np      <= np_d;
            one_p   <= one_p_d;
            one_m   <= one_m_d;
            two_m   <= two_m_d;
            sign    <= sign_d;
            one     <= one_d;
            two     <= two_d;
            cor     <= cor_d;
            out_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nr4sdm_recoder_unit.sv
// Self-checking bench for nr4sdm_recoder_unit: directed vectors plus random
// digit-sum / select / partial-product checks.
module tb_nr4sdm_recoder_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] a;
    logic [6:0]  nm, np, one_p, one_m, two_m;
    logic        sign, one, two;
    logic [31:0] cor;
    logic        out_vld;

    int n_cmp = 0;
    int n_err = 0;

    nr4sdm_recoder_unit dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .nm      (nm),
        .np      (np),
        .one_p   (one_p),
        .one_m   (one_m),
        .two_m   (two_m),
        .sign    (sign),
        .one     (one),
        .two     (two),
        .cor     (cor),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [6:0] e_nm, input logic [6:0] e_np,
                           input logic [6:0] e_op, input logic [6:0] e_om,
                           input logic [6:0] e_tm, input logic e_s,
                           input logic e_o, input logic e_t,
                           input logic [31:0] e_cor, input logic e_vld);
        chk({tag, ".nm"},    32'(nm),      32'(e_nm));
        chk({tag, ".np"},    32'(np),      32'(e_np));
        chk({tag, ".one_p"}, 32'(one_p),   32'(e_op));
        chk({tag, ".one_m"}, 32'(one_m),   32'(e_om));
        chk({tag, ".two_m"}, 32'(two_m),   32'(e_tm));
        chk({tag, ".sign"},  32'(sign),    32'(e_s));
        chk({tag, ".one"},   32'(one),     32'(e_o));
        chk({tag, ".two"},   32'(two),     32'(e_t));
        chk({tag, ".cor"},   cor,          e_cor);
        chk({tag, ".vld"},   32'(out_vld), 32'(e_vld));
    endtask

    initial begin
        logic [15:0] b;
        logic [16:0] p;
        logic [31:0] acc;
        logic [2:0]  sel;
        int          ds, absd, d7, prod, bad_sel;
        logic        neg;

        rst = 1'b1; en = 1'b0; a = 16'h0000;
        step(); step();
        chk_all("reset", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        en = 1'b1; a = 16'h0B1E; step();
        chk_all("a0b1e", 7'b0110101, 7'b1111000, 7'b1001000, 7'b0110000, 7'b0000101,
                1'b0, 1'b0, 1'b0, 32'hF5DE0511, 1'b1);

        a = 16'h8000; step();
        chk_all("a8000", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1'b1, 1'b0, 1'b1, 32'h80004000, 1'b1);

        a = 16'hFFFF; step();
        chk_all("affff", 7'b0000001, 7'b0000001, 7'h00, 7'b0000001, 7'h00,
                1'b1, 1'b0, 1'b0, 32'h7FFE4001, 1'b1);

        a = 16'h5555; step();
        chk_all("a5555", 7'h00, 7'h7F, 7'h7F, 7'h00, 7'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        a = 16'h7FFF; step();
        chk_all("a7fff", 7'b0000001, 7'b0000001, 7'h00, 7'b0000001, 7'h00,
                1'b0, 1'b0, 1'b1, 32'hFFFE0001, 1'b1);

        // en=0: outputs keep the 7FFF recoding while a changes
        en = 1'b0; a = 16'h0B1E; step(); step();
        chk_all("hold", 7'b0000001, 7'b0000001, 7'h00, 7'b0000001, 7'h00,
                1'b0, 1'b0, 1'b1, 32'hFFFE0001, 1'b1);

        // reset wins over en
        en = 1'b1; a = 16'hFFFF; rst = 1'b1; step();
        chk_all("rst_mid", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        for (int it = 0; it < 10000; it++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            step();

            ds = 0;
            bad_sel = 0;
            for (int j = 0; j < 7; j++) begin
                ds += (int'(np[j]) - 2 * int'(nm[j])) * (1 << (2 * j));
                sel = {one_p[j], one_m[j], two_m[j]};
                if ($countones(sel) > 1) bad_sel = 1;
            end
            if (one && two) bad_sel = 1;
            d7 = one ? 1 : (two ? 2 : 0);
            if (sign) d7 = -d7;
            ds += d7 * 16384;
            chk("digit_sum", 32'(ds), 32'(int'($signed(a))));
            chk("sel_onehot", 32'(bad_sel), 32'(0));

            acc = cor;
            for (int j = 0; j < 8; j++) begin
                if (j < 7) begin
                    neg  = one_m[j] | two_m[j];
                    absd = (one_p[j] | one_m[j]) ? 1 : (two_m[j] ? 2 : 0);
                end else begin
                    neg  = sign;
                    absd = one ? 1 : (two ? 2 : 0);
                end
                p = 17'(absd * int'(b));
                if (neg) p = ~p;
                acc = acc + ({15'b0, p} << (2 * j));
            end
            prod = int'($signed(a)) * int'(b);
            chk("pp_sum", acc, 32'(prod));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
